// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet MII constants and the rtlput/rtlget state encoding.
package eth_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DLO, S_DHI, S_PAD, S_FCS, S_IFG} state_e;
  localparam logic [3:0] ETH_PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] ETH_SFD_NIB = 4'hD;
  localparam logic [31:0] ETH_CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
endpackage

// File: rtl/crc32_nib.sv
// crc32_nib: one 4-bit step of the reflected Ethernet CRC-32.
module crc32_nib
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [3:0]  nib,
  output logic [31:0] crc_out
);
  always_comb begin
    crc_out = crc_in ^ {28'h0, nib};
    for (int i = 0; i < 4; i++) crc_out = crc_out[0] ? (crc_out >> 1) ^ ETH_CRC_POLY : crc_out >> 1;
  end
endmodule

// File: rtl/rtlput.sv
// rtlput: MII transmit engine (preamble, SFD, payload, pad, FCS, IFG) for the RTL8201 PHY.
// Define RTLPUT_FCS_EN to append the CRC-32 FCS; otherwise upstream supplies it in the payload.
module rtlput
  import eth_pkg::*;
#(
  parameter int IFG_NIBBLES = 24,
  parameter int MIN_FRAME = 60,
  parameter bit BITREV = 1'b0
) (
  input  logic       rtl_clk,
  input  logic       resetb,
  input  logic [7:0] data,
  input  logic       valid,
  input  logic       last,
  output logic       ready,
  output logic [3:0] txd,
  output logic       txen,
  output logic       busy,
  output logic       underrun
);
`ifdef RTLPUT_FCS_EN
  localparam state_e TAIL = S_FCS;
`else
  localparam state_e TAIL = S_IFG;
`endif
  state_e state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic last_q, last_d;
  logic [10:0] bytecnt_q, bytecnt_d, bc_inc;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0] nib_d, fcs_nib, txd_q;
  logic txen_q, txen_d, underrun_q, underrun_d;
  assign bc_inc = (bytecnt_q == 11'h7FF) ? bytecnt_q : bytecnt_q + 11'd1;
  assign busy = state_q != S_IDLE;
  assign txd = txd_q;
  assign txen = txen_q;
  assign underrun = underrun_q;
  always_comb begin
    state_d = state_q;
    byte_d = byte_q;
    last_d = last_q;
    bytecnt_d = bytecnt_q;
    underrun_d = 1'b0;
    ready = 1'b0;
    case (state_q)
      S_IDLE: if (valid) state_d = S_PRE;
      S_PRE: if (cnt_q == 16'd14) state_d = S_SFD;
      S_SFD: begin
        ready = 1'b1;
        bytecnt_d = '0;
        if (valid) begin
          byte_d = data;
          last_d = last;
          state_d = S_DLO;
        end else begin
          underrun_d = 1'b1;
          state_d = S_IFG;
        end
      end
      S_DLO: state_d = S_DHI;
      S_DHI: begin
        ready = !last_q;
        bytecnt_d = bc_inc;
        if (last_q) state_d = (int'(bc_inc) < MIN_FRAME) ? S_PAD : TAIL;
        else if (valid) begin
          byte_d = data;
          last_d = last;
          state_d = S_DLO;
        end else begin
          underrun_d = 1'b1;
          state_d = S_IFG;
        end
      end
      S_PAD: if (cnt_q[0]) begin
        bytecnt_d = bc_inc;
        if (int'(bc_inc) >= MIN_FRAME) state_d = TAIL;
      end
      S_FCS: if (cnt_q == 16'd7) state_d = S_IFG;
      S_IFG: if (int'(cnt_q) >= IFG_NIBBLES - 2) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // Outputs are registered from the next state, so txd/txen show the state being entered.
  always_comb begin
    cnt_d = (state_d == state_q) ? cnt_q + 16'd1 : '0;
    txen_d = !(state_d inside {S_IDLE, S_IFG});
    nib_d = (state_d == S_PRE) ? ETH_PREAMBLE_NIB :
            (state_d == S_SFD) ? ETH_SFD_NIB :
            (state_d == S_DLO) ? byte_d[3:0] :
            (state_d == S_DHI) ? byte_d[7:4] :
            (state_d == S_FCS) ? fcs_nib : 4'h0;
  end
`ifdef RTLPUT_FCS_EN
  logic [31:0] crc_q, crc_d, crc_upd;
  crc32_nib u_crc (.crc_in(crc_q), .nib(nib_d), .crc_out(crc_upd));
  assign fcs_nib = ~crc_q[3:0];
  assign crc_d = (state_d == S_SFD) ? ETH_CRC_INIT :
                 (state_d == S_FCS) ? crc_q >> 4 :
                 (state_d inside {S_DLO, S_DHI, S_PAD}) ? crc_upd : crc_q;
  always_ff @(posedge rtl_clk or negedge resetb)
    if (!resetb) crc_q <= ETH_CRC_INIT;
    else crc_q <= crc_d;
`else
  assign fcs_nib = 4'h0;
`endif
  always_ff @(posedge rtl_clk or negedge resetb)
    if (!resetb) begin
      state_q <= S_IDLE;
      byte_q <= '0;
      last_q <= 1'b0;
      bytecnt_q <= '0;
      cnt_q <= '0;
      txd_q <= '0;
      txen_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q <= byte_d;
      last_q <= last_d;
      bytecnt_q <= bytecnt_d;
      cnt_q <= cnt_d;
      txd_q <= BITREV ? {nib_d[0], nib_d[1], nib_d[2], nib_d[3]} : nib_d;
      txen_q <= txen_d;
      underrun_q <= underrun_d;
    end
endmodule

// File: tb/tb_rtlput.sv
// tb_rtlput: scoreboard bench for rtlput; three instances cover plain, padded and bit-reversed builds.
module tb_rtlput;
  import eth_pkg::*;
  localparam int IFG = 24;
  logic clk = 1'b0;
  logic resetb = 1'b1;
  logic [7:0] data = '0;
  logic last = 1'b0;
  logic valid_s = 1'b0;
  int sel = 0;
  logic valid_a, valid_b, valid_c, ready_a, ready_b, ready_c, txen_a, txen_b, txen_c;
  logic busy_a, busy_b, busy_c, und_a, und_b, und_c;
  logic [3:0] txd_a, txd_b, txd_c;
  logic ready_s, txen_s, busy_s, und_s;
  logic [3:0] txd_s;
  logic [3:0] exp_q[$];
  logic [3:0] wire_q[$];
  int len_q[$];
  int errors = 0, checks = 0;
  bit in_frame = 0, seen = 0, aborting = 0;
  int nib_idx = 0, low_run = 0, last_gap = -1;

  always #5 clk = ~clk;
  assign valid_a = valid_s && sel == 0;
  assign valid_b = valid_s && sel == 1;
  assign valid_c = valid_s && sel == 2;
  assign ready_s = sel == 1 ? ready_b : sel == 2 ? ready_c : ready_a;
  assign txen_s = sel == 1 ? txen_b : sel == 2 ? txen_c : txen_a;
  assign busy_s = sel == 1 ? busy_b : sel == 2 ? busy_c : busy_a;
  assign und_s = sel == 1 ? und_b : sel == 2 ? und_c : und_a;
  assign txd_s = sel == 1 ? txd_b : sel == 2 ? txd_c : txd_a;

  rtlput #(.IFG_NIBBLES(IFG), .MIN_FRAME(0), .BITREV(1'b0)) dut_a (.rtl_clk(clk), .resetb(resetb),
    .data(data), .valid(valid_a), .last(last), .ready(ready_a), .txd(txd_a), .txen(txen_a),
    .busy(busy_a), .underrun(und_a));
  rtlput #(.IFG_NIBBLES(IFG), .MIN_FRAME(60), .BITREV(1'b0)) dut_b (.rtl_clk(clk), .resetb(resetb),
    .data(data), .valid(valid_b), .last(last), .ready(ready_b), .txd(txd_b), .txen(txen_b),
    .busy(busy_b), .underrun(und_b));
  rtlput #(.IFG_NIBBLES(IFG), .MIN_FRAME(0), .BITREV(1'b1)) dut_c (.rtl_clk(clk), .resetb(resetb),
    .data(data), .valid(valid_c), .last(last), .ready(ready_c), .txd(txd_c), .txen(txen_c),
    .busy(busy_c), .underrun(und_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] rv(input logic [3:0] n, input bit r);
    return r ? {n[0], n[1], n[2], n[3]} : n;
  endfunction

  function automatic logic [31:0] fcs_of(input logic [7:0] p[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (p[i]) for (int k = 0; k < 8; k++) c = (c[0] ^ p[i][k]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return ~c;
  endfunction

  task automatic expect_frame(input logic [7:0] b[$], input int minf, input bit rev);
    logic [7:0] p[$];
    int n;
`ifdef RTLPUT_FCS_EN
    logic [31:0] f;
`endif
    p = b;
    while (p.size() < minf) p.push_back(8'h00);
    for (int i = 0; i < 15; i++) exp_q.push_back(rv(4'h5, rev));
    exp_q.push_back(rv(4'hD, rev));
    foreach (p[i]) begin
      exp_q.push_back(rv(p[i][3:0], rev));
      exp_q.push_back(rv(p[i][7:4], rev));
    end
    n = 16 + 2 * p.size();
`ifdef RTLPUT_FCS_EN
    f = fcs_of(p);
    for (int i = 0; i < 8; i++) exp_q.push_back(rv(f[4*i +: 4], rev));
    n += 8;
`endif
    len_q.push_back(n);
  endtask

  task automatic send(input logic [7:0] b[$], input int minf, input bit rev, input bit keep);
    int t;
    expect_frame(b, minf, rev);
    foreach (b[i]) begin
      data = b[i];
      last = (i == b.size() - 1);
      valid_s = 1'b1;
      t = 0;
      while (!ready_s && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) begin
        chk("ready_timeout", t, 0);
        valid_s = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (!keep) begin valid_s = 1'b0; last = 1'b0; end
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || in_frame || busy_s) && t < 3000) begin @(posedge clk); #1; t++; end
    chk("done_timeout", t < 3000, 1);
  endtask

  // Monitor: every nibble on the wire is popped against the scoreboard, every frame span checked.
  initial forever begin
    @(negedge clk);
    if (txen_s) begin
      if (!in_frame) begin
        in_frame = 1;
        nib_idx = 0;
        wire_q.delete();
        if (seen) last_gap = low_run;
      end
      wire_q.push_back(txd_s);
      nib_idx++;
      chk("nib_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("nibble", txd_s, exp_q.pop_front());
    end else begin
      if (in_frame) begin
        in_frame = 0;
        seen = 1;
        low_run = 0;
        if (!aborting && len_q.size() > 0) chk("txen_span", nib_idx, len_q.pop_front());
      end
      low_run++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] s9[$];
    logic [7:0] b14[$];
    int n, t;
`ifdef RTLPUT_FCS_EN
    logic [31:0] r;
`endif
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int i = 0; i < 14; i++) b14.push_back(8'(i * 17 + 3));
    #2 resetb = 1'b0;
    @(negedge clk);
    chk("rst_txd", txd_a, 0);
    chk("rst_txen", txen_a, 0);
    chk("rst_ready", ready_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_underrun", und_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_busy_c", busy_c, 0);
    @(posedge clk); #1 resetb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_txen", txen_a, 0);
    // 9-byte "123456789", no padding
    send(s9, 0, 0, 0);
    wait_done();
    // 14-byte frame padded to 60 bytes
    sel = 1;
    send(b14, 60, 0, 0);
    wait_done();
`ifdef RTLPUT_FCS_EN
    r = 32'hFFFFFFFF;
    for (int i = 16; i < wire_q.size(); i++)
      for (int k = 0; k < 4; k++) r = (r[0] ^ wire_q[i][k]) ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    chk("rx_residue", r, ETH_CRC_RESIDUE);
`endif
    // underrun: one byte accepted at SFD, then valid dropped through DHI
    sel = 0;
    for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h1);
    len_q.push_back(18);
    data = 8'h11;
    last = 1'b0;
    valid_s = 1'b1;
    t = 0;
    while (!ready_s && t < 2000) begin @(negedge clk); t++; end
    @(posedge clk); #1 valid_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("underrun_pulse", und_s, 1);
    chk("underrun_txen", txen_s, 0);
    chk("underrun_busy", busy_s, 1);
    @(posedge clk); #1;
    chk("underrun_single", und_s, 0);
    n = 1;
    while (busy_s && n < 200) begin @(posedge clk); #1; n++; end
    chk("abort_ifg_len", n, IFG - 1);
    wait_done();
    // back-to-back frames with valid held high
    send(s9, 0, 0, 1);
    send(b14, 0, 0, 0);
    wait_done();
    chk("b2b_gap", last_gap, IFG);
    // reset in the middle of the frame tail
    aborting = 1;
    send(s9, 0, 0, 0);
    t = 0;
`ifdef RTLPUT_FCS_EN
    while (nib_idx < 37 && t < 2000) begin @(posedge clk); t++; end
`endif
    #2 resetb = 1'b0;
    #1;
    chk("rst_mid_txen", txen_s, 0);
    chk("rst_mid_txd", txd_s, 0);
    repeat (3) @(posedge clk);
    exp_q.delete();
    len_q.delete();
    aborting = 0;
    #1 resetb = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_busy", busy_s, 0);
    chk("post_rst_txen", txen_s, 0);
    send(s9, 0, 0, 0);
    wait_done();
    // bit-reversed wiring
    sel = 2;
    send(s9, 0, 1, 0);
    wait_done();
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
